// File: rtl/aes128_round_seq.sv
// Iterative AES-128 encryptor: one shared round datapath, one round per clock.
// Optional macro AES_KEY_REUSE_EN adds in_key_reuse to encrypt again under the last loaded key.
module aes128_round_seq #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
`ifdef AES_KEY_REUSE_EN
  input  logic         in_key_reuse,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t            state;
  logic [127:0]      st, kreg, key_sel, rk, round_out;
  logic [7:0]        rcon;
  logic [15:0][7:0]  sb, sr;
  logic [7:0]        a0, a1, a2, a3;
  logic [31:0]       mc, sw, w4, w5, w6, w7;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // SBOX: multiplicative inverse as a^254 (0 maps to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

`ifdef AES_KEY_REUSE_EN
  logic [127:0] kbase;
  logic         key_vld;
  logic         use_base;
  assign use_base = in_key_reuse && key_vld;
  assign key_sel  = use_base ? kbase : in_key;
`else
  assign key_sel  = in_key;
`endif

  // Byte i of the state lives at bits [127-8i -: 8]; byte i sits in row i%4, column i/4.
  always_comb begin
    sb        = '0;
    sr        = '0;
    round_out = '0;
    mc        = '0;
    a0        = '0;
    a1        = '0;
    a2        = '0;
    a3        = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(st[8*(15-i) +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    sw = {sbox(kreg[23:16]), sbox(kreg[15:8]), sbox(kreg[7:0]), sbox(kreg[31:24])};
    w4 = kreg[127:96] ^ sw ^ {rcon, 24'h0};
    w5 = kreg[95:64] ^ w4;
    w6 = kreg[63:32] ^ w5;
    w7 = kreg[31:0] ^ w6;
    rk = {w4, w5, w6, w7};
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (round == NR_L) mc = {a0, a1, a2, a3};
      else mc = {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
                 a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
                 a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
                 mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
      round_out[32*(3-c) +: 32] = mc ^ rk[32*(3-c) +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      st        <= '0;
      kreg      <= '0;
      rcon      <= 8'h01;
      round     <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
`ifdef AES_KEY_REUSE_EN
      kbase     <= '0;
      key_vld   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            st       <= in_data ^ key_sel;
            kreg     <= key_sel;
            rcon     <= 8'h01;
            round    <= 4'd1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ROUND;
`ifdef AES_KEY_REUSE_EN
            if (!use_base) kbase <= in_key;
            key_vld <= 1'b1;
`endif
          end
        end
        ROUND: begin
          st   <= round_out;
          kreg <= rk;
          rcon <= xtime(rcon);
          // The ciphertext is captured separately so intermediate round states never reach out_data.
          if (round == NR_L) begin
            out_valid <= 1'b1;
            out_data  <= round_out;
            state     <= DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            round     <= 4'd0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_round_seq.sv
// Self-checking bench for aes128_round_seq: known-answer vectors plus random blocks
// compared against a table-driven AES-128 model; key-reuse cases when AES_KEY_REUSE_EN is set.
module tb_aes128_round_seq;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, in_key, out_data;
  logic [3:0]   round;
`ifdef AES_KEY_REUSE_EN
  logic         in_key_reuse;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] sbox_t [256];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes128_round_seq dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_key(in_key),
`ifdef AES_KEY_REUSE_EN
    .in_key_reuse(in_key_reuse),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy),
    .round(round)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box table built by walking the generator 3 and its inverse through the field.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b & 1) p = p ^ a;
      a = a << 1;
      if (a & 'h100) a = a ^ 'h11b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   w [44][4];
    logic [7:0]   tmp [4];
    logic [7:0]   rc;
    logic [127:0] res;
    int           m [4];
    int           acc;
    m = '{2, 3, 1, 1};
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127-8*i -: 8];
      w[i/4][i%4] = key[127-8*i -: 8];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % 4 == 0) begin
        tmp[0] = sbox_t[w[i-1][1]] ^ rc;
        tmp[1] = sbox_t[w[i-1][2]];
        tmp[2] = sbox_t[w[i-1][3]];
        tmp[3] = sbox_t[w[i-1][0]];
        rc = 8'(gmul(int'(rc), 2));
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i/4][i%4];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = 0;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[(k-r+4)%4], int'(t[k+4*c]));
            s[r+4*c] = 8'(acc);
          end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][i%4];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one block, scrambles the inputs after acceptance and
  // drains the ciphertext; lat counts edges from acceptance to out_valid.
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                           output logic [127:0] ct, output int lat, output bit timed_out);
    int n;
    timed_out = 1'b0;
    lat = 0;
    ct = '0;
    n = 0;
    while (!in_ready && n < 30) begin step(); n++; end
    if (!in_ready) begin timed_out = 1'b1; return; end
    in_key = key;
    in_data = pt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_key = {4{$urandom}};
    in_data = {4{$urandom}};
    while (!out_valid && lat < 40) begin step(); lat++; end
    if (!out_valid) begin timed_out = 1'b1; return; end
    ct = out_data;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({in_ready, out_valid, busy, round} !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got in_ready/out_valid/busy/round=%b want 1000000",
               {in_ready, out_valid, busy, round});
    end
    checks++;
    if (out_data !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_out_data: got %h want 0", out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_fips_b();
    logic [127:0] ct;
    int lat;
    bit to;
    run_block(KEY_B, PT_B, ct, lat, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL fips_b_timeout: got timeout want completion"); end
    checks++;
    if (ct !== CT_B) begin errors++; $display("[TB] FAIL fips_b_ct: got %h want %h", ct, CT_B); end
    checks++;
    if (lat !== 10) begin errors++; $display("[TB] FAIL fips_b_latency: got %0d want 10", lat); end
  endtask

  task automatic test_fips_c1_rounds();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL c1_ready: got %b want 1", in_ready);
    end
    in_key = KEY_C;
    in_data = PT_C;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_key = '0;
    in_data = '0;
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if ({round, busy, out_valid} !== {4'(k), 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL c1_round_step: got round=%0d busy=%b out_valid=%b want round=%0d busy=1 out_valid=0",
                 round, busy, out_valid, k);
      end
      step();
    end
    checks++;
    if ({out_valid, round} !== {1'b1, 4'd10}) begin
      errors++;
      $display("[TB] FAIL c1_done: got out_valid=%b round=%0d want out_valid=1 round=10", out_valid, round);
    end
    checks++;
    if (out_data !== CT_C) begin
      errors++;
      $display("[TB] FAIL c1_ct: got %h want %h", out_data, CT_C);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({round, in_ready, busy, out_valid} !== 7'b0000100) begin
      errors++;
      $display("[TB] FAIL c1_idle: got round/in_ready/busy/out_valid=%b want 0000100",
               {round, in_ready, busy, out_valid});
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] key, pt, held, ct;
    int n;
    key = {4{$urandom}};
    pt = {4{$urandom}};
    in_key = key;
    in_data = pt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    checks++;
    if (!out_valid) begin errors++; $display("[TB] FAIL bp_timeout: got out_valid=0 want 1"); end
    held = out_data;
    checks++;
    if (held !== aes_ref(key, pt)) begin
      errors++;
      $display("[TB] FAIL bp_ct: got %h want %h", held, aes_ref(key, pt));
    end
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = {4{$urandom}};
      in_key = {4{$urandom}};
      step();
      checks++;
      if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold: cycle %0d got data=%h valid=%b ready=%b want data=%h valid=1 ready=0",
                 i, out_data, out_valid, in_ready, held);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL bp_release: got out_valid/in_ready/busy=%b want 010", {out_valid, in_ready, busy});
    end
    key = {4{$urandom}};
    pt = {4{$urandom}};
    in_key = key;
    in_data = pt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({busy, round} !== {1'b1, 4'd1}) begin
      errors++;
      $display("[TB] FAIL bp_next_accept: got busy=%b round=%0d want busy=1 round=1", busy, round);
    end
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    ct = out_data;
    checks++;
    if (!out_valid || ct !== aes_ref(key, pt)) begin
      errors++;
      $display("[TB] FAIL bp_next_ct: got valid=%b data=%h want valid=1 data=%h", out_valid, ct, aes_ref(key, pt));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [127:0] ct;
    int lat;
    bit to;
    bit seen;
    in_key = KEY_B;
    in_data = PT_B;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    checks++;
    if (round !== 4'd5) begin errors++; $display("[TB] FAIL rst_mid_round5: got %0d want 5", round); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, round, out_valid, in_ready} !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL rst_mid_state: got busy/round/out_valid/in_ready=%b want 0000001",
               {busy, round, out_valid, in_ready});
    end
    seen = 1'b0;
    repeat (12) begin step(); if (out_valid) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("[TB] FAIL rst_mid_no_output: got out_valid=1 want 0"); end
    run_block(KEY_B, PT_B, ct, lat, to);
    checks++;
    if (to || ct !== CT_B) begin
      errors++;
      $display("[TB] FAIL rst_mid_after_ct: got %h (timeout=%b) want %h", ct, to, CT_B);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ct1, ct2;
    int t, t1, t2;
    ct1 = '0;
    ct2 = '0;
    out_ready = 1'b1;
    in_key = KEY_B;
    in_data = PT_B;
    in_valid = 1'b1;
    step();
    in_key = KEY_C;
    in_data = PT_C;
    t = 0;
    t1 = -1;
    t2 = -1;
    while (t2 < 0 && t < 60) begin
      if (out_valid) begin
        if (t1 < 0) begin t1 = t; ct1 = out_data; end
        else begin t2 = t; ct2 = out_data; end
      end
      if (t2 < 0) begin step(); t++; end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    checks++;
    if (t1 < 0 || t2 < 0) begin
      errors++;
      $display("[TB] FAIL b2b_timeout: got t1=%0d t2=%0d want both seen", t1, t2);
    end
    checks++;
    if (ct1 !== CT_B) begin errors++; $display("[TB] FAIL b2b_ct1: got %h want %h", ct1, CT_B); end
    checks++;
    if (ct2 !== CT_C) begin errors++; $display("[TB] FAIL b2b_ct2: got %h want %h", ct2, CT_C); end
    checks++;
    if (t1 !== 10) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d want 10", t1); end
    // One DONE cycle, one IDLE cycle, then ten rounds: out_valid is low for 11 cycles in between.
    checks++;
    if (t2 - t1 - 1 !== 11) begin
      errors++;
      $display("[TB] FAIL b2b_gap: got %0d low cycles want 11", t2 - t1 - 1);
    end
  endtask

  task automatic test_random();
    logic [127:0] key, pt, ct;
    int lat;
    bit to;
    for (int i = 0; i < 6; i++) begin
      key = {4{$urandom}};
      pt = {4{$urandom}};
      run_block(key, pt, ct, lat, to);
      checks++;
      if (to || ct !== aes_ref(key, pt)) begin
        errors++;
        $display("[TB] FAIL random_ct: block %0d got %h (timeout=%b) want %h", i, ct, to, aes_ref(key, pt));
      end
      checks++;
      if (lat !== 10) begin errors++; $display("[TB] FAIL random_latency: block %0d got %0d want 10", i, lat); end
    end
  endtask

`ifdef AES_KEY_REUSE_EN
  task automatic test_key_reuse();
    logic [127:0] ct, pt;
    int lat;
    bit to;
    in_key_reuse = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_block(KEY_C, PT_C, ct, lat, to);
    checks++;
    if (to || ct !== CT_C) begin errors++; $display("[TB] FAIL reuse_load: got %h want %h", ct, CT_C); end
    in_key_reuse = 1'b1;
    run_block(128'h0, PT_B, ct, lat, to);
    checks++;
    if (to || ct !== aes_ref(KEY_C, PT_B)) begin
      errors++;
      $display("[TB] FAIL reuse_c1_key: got %h want %h", ct, aes_ref(KEY_C, PT_B));
    end
    pt = {4{$urandom}};
    run_block({4{$urandom}}, pt, ct, lat, to);
    checks++;
    if (to || ct !== aes_ref(KEY_C, pt)) begin
      errors++;
      $display("[TB] FAIL reuse_random: got %h want %h", ct, aes_ref(KEY_C, pt));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_block(KEY_B, PT_B, ct, lat, to);
    checks++;
    if (to || ct !== CT_B) begin errors++; $display("[TB] FAIL reuse_no_vld: got %h want %h", ct, CT_B); end
    run_block(128'h0, PT_C, ct, lat, to);
    checks++;
    if (to || ct !== aes_ref(KEY_B, PT_C)) begin
      errors++;
      $display("[TB] FAIL reuse_after_vld: got %h want %h", ct, aes_ref(KEY_B, PT_C));
    end
    in_key_reuse = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    in_key = '0;
`ifdef AES_KEY_REUSE_EN
    in_key_reuse = 1'b0;
`endif
    build_sbox();
    test_reset();
    test_fips_b();
    test_fips_c1_rounds();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef AES_KEY_REUSE_EN
    test_key_reuse();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
